// File: rtl/mostrador_atributos.sv
// mostrador_atributos
// Shows the pet attributes on a 4-digit multiplexed 7-segment display.
// The display steps through four pages (fome, felicidade, sono, estado).
// On each page it shows a page letter on the leftmost digit and the
// page value in decimal (000-255) on the other three digits.
// While the pet is dead the display shows "dEAd" instead.
//
// Parameters:
//   SCAN_DIV  clk cycles per digit-scan step (>= 2)
//   PAGE_DIV  clk cycles per displayed page   (>= 16)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active-high
//   estado      in   [2:0] pet state code (shown zero-extended)
//   fome        in   [7:0] hunger value
//   felicidade  in   [7:0] happiness value
//   sono        in   [7:0] sleepiness value
//   morreu      in   pet-dead flag, overrides the digits immediately
//   seg         out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   an          out  [3:0] digit enables, active-low, an[3] leftmost
//   pagina      out  [1:0] current page 0..3
//
// Build option:
//   MOSTRADOR_SUPRESSAO_ZEROS_EN  blank leading zeros on digits 2 and 1
module mostrador_atributos #(
   parameter int SCAN_DIV = 50000,
   parameter int PAGE_DIV = 100000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] estado,
   input  logic [7:0] fome,
   input  logic [7:0] felicidade,
   input  logic [7:0] sono,
   input  logic       morreu,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic [1:0] pagina
);

   localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int PW = $clog2(PAGE_DIV);

   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] PAGE_LAST = PW'(PAGE_DIV - 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_S     = 7'b0010010;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_LD    = 7'b0100001;
   localparam logic [6:0] SEG_A     = 7'b0001000;

   typedef enum logic [1:0] {
      PG_FOME    = 2'd0,
      PG_FELIC   = 2'd1,
      PG_SONO    = 2'd2,
      PG_ESTADO  = 2'd3
   } page_t;

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
   // Layout is {hundreds, tens, units, binary[7:0]}.
   function automatic logic [19:0] dd_step(input logic [19:0] w);
      logic [19:0] t;
      t = w;
      for (int i = 0; i < 3; i++) begin
         if (t[8 + 4*i +: 4] >= 4'd5) begin
            t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
         end else begin
            t[8 + 4*i +: 4] = t[8 + 4*i +: 4];
         end
      end
      return {t[18:0], 1'b0};
   endfunction

   // BCD digit to active-low segment pattern.
   function automatic logic [6:0] seg_digit(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Page letter for the leftmost digit.
   function automatic logic [6:0] seg_letter(input page_t p);
      logic [6:0] s;
      case (p)
         PG_FOME:   s = SEG_F;
         PG_FELIC:  s = SEG_C;
         PG_SONO:   s = SEG_S;
         PG_ESTADO: s = SEG_E;
         default:   s = SEG_BLANK;
      endcase
      return s;
   endfunction

   page_t          state_q, state_d;
   page_t          disp_page_q, disp_page_d;
   logic [PW-1:0]  page_cnt_q, page_cnt_d;
   logic [SW-1:0]  scan_cnt_q, scan_cnt_d;
   logic [3:0]     an_q, an_d;
   logic           first_q, first_d;
   logic [7:0]     snap_q, snap_d;
   logic [19:0]    work_q, work_d;
   logic [3:0]     step_q, step_d;
   logic           busy_q, busy_d;
   logic [11:0]    bcd_q, bcd_d;
   logic           entry_s;
   logic [7:0]     page_val_s;
   logic [6:0]     norm_seg_s;
   logic [6:0]     dead_seg_s;
   logic           blank_h_s;
   logic           blank_t_s;

   // State register for the page FSM, converter and scan.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= PG_FOME;
         disp_page_q <= PG_FOME;
         page_cnt_q  <= '0;
         scan_cnt_q  <= '0;
         an_q        <= 4'b0111;
         first_q     <= 1'b1;
         snap_q      <= 8'd0;
         work_q      <= 20'd0;
         step_q      <= 4'd0;
         busy_q      <= 1'b0;
         bcd_q       <= 12'd0;
      end else begin
         state_q     <= state_d;
         disp_page_q <= disp_page_d;
         page_cnt_q  <= page_cnt_d;
         scan_cnt_q  <= scan_cnt_d;
         an_q        <= an_d;
         first_q     <= first_d;
         snap_q      <= snap_d;
         work_q      <= work_d;
         step_q      <= step_d;
         busy_q      <= busy_d;
         bcd_q       <= bcd_d;
      end
   end

   // Next-state logic: page sequencing, snapshot, conversion and scan.
   always_comb begin
      state_d     = state_q;
      disp_page_d = disp_page_q;
      page_cnt_d  = page_cnt_q;
      scan_cnt_d  = scan_cnt_q;
      an_d        = an_q;
      first_d     = 1'b0;
      snap_d      = snap_q;
      work_d      = work_q;
      step_d      = step_q;
      busy_d      = busy_q;
      bcd_d       = bcd_q;
      entry_s     = 1'b0;
      page_val_s  = 8'd0;

      // The first edge after reset is the entry into FOME; afterwards a page
      // is entered every PAGE_DIV cycles.
      if (first_q) begin
         entry_s    = 1'b1;
         page_cnt_d = '0;
      end else if (page_cnt_q == PAGE_LAST) begin
         entry_s    = 1'b1;
         page_cnt_d = '0;
         case (state_q)
            PG_FOME:   state_d = PG_FELIC;
            PG_FELIC:  state_d = PG_SONO;
            PG_SONO:   state_d = PG_ESTADO;
            PG_ESTADO: state_d = PG_FOME;
            default:   state_d = PG_FOME;
         endcase
      end else begin
         page_cnt_d = page_cnt_q + PW'(1);
      end

      case (state_d)
         PG_FOME:   page_val_s = fome;
         PG_FELIC:  page_val_s = felicidade;
         PG_SONO:   page_val_s = sono;
         PG_ESTADO: page_val_s = {5'd0, estado};
         default:   page_val_s = 8'd0;
      endcase

      // Entry: capture the value. Next 8 cycles: shifts. Ninth: publish.
      if (entry_s) begin
         snap_d = page_val_s;
         step_d = 4'd0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (step_q < 4'd8) begin
            work_d = dd_step((step_q == 4'd0) ? {12'd0, snap_q} : work_q);
            step_d = step_q + 4'd1;
         end else begin
            bcd_d       = work_q[19:8];
            disp_page_d = state_q;
            busy_d      = 1'b0;
         end
      end else begin
         busy_d = 1'b0;
      end

      // Rotate the single low enable bit right: 3,2,1,0,3...
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         an_d       = {an_q[0], an_q[3:1]};
      end else begin
         scan_cnt_d = scan_cnt_q + SW'(1);
      end
   end

`ifdef MOSTRADOR_SUPRESSAO_ZEROS_EN
   assign blank_h_s = (bcd_q[11:8] == 4'd0);
   assign blank_t_s = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
`else
   assign blank_h_s = 1'b0;
   assign blank_t_s = 1'b0;
`endif

   // Segment pattern for the active digit, normal and dead variants.
   always_comb begin
      norm_seg_s = SEG_BLANK;
      dead_seg_s = SEG_BLANK;
      case (an_q)
         4'b0111: begin
            norm_seg_s = seg_letter(disp_page_q);
            dead_seg_s = SEG_LD;
         end
         4'b1011: begin
            norm_seg_s = blank_h_s ? SEG_BLANK : seg_digit(bcd_q[11:8]);
            dead_seg_s = SEG_E;
         end
         4'b1101: begin
            norm_seg_s = blank_t_s ? SEG_BLANK : seg_digit(bcd_q[7:4]);
            dead_seg_s = SEG_A;
         end
         4'b1110: begin
            norm_seg_s = seg_digit(bcd_q[3:0]);
            dead_seg_s = SEG_LD;
         end
         default: begin
            norm_seg_s = SEG_BLANK;
            dead_seg_s = SEG_BLANK;
         end
      endcase
   end

   // morreu acts without a register stage so release is seen the same cycle;
   // the display stays blank until the first edge after reset.
   assign seg    = first_q ? SEG_BLANK : (morreu ? dead_seg_s : norm_seg_s);
   assign an     = an_q;
   assign pagina = state_q;

endmodule

// File: tb/tb_mostrador_atributos.sv
// Directed testbench for mostrador_atributos with SCAN_DIV=4, PAGE_DIV=64.
// cyc counts rising edges since the page-0 entry edge after reset release.
module tb_mostrador_atributos;

   localparam logic [6:0] BL  = 7'b1111111;
   localparam logic [6:0] LF  = 7'b0001110;
   localparam logic [6:0] LC  = 7'b1000110;
   localparam logic [6:0] LS  = 7'b0010010;
   localparam logic [6:0] LE  = 7'b0000110;
   localparam logic [6:0] LDD = 7'b0100001;
   localparam logic [6:0] LA  = 7'b0001000;

   logic       clk;
   logic       rst;
   logic [2:0] estado;
   logic [7:0] fome;
   logic [7:0] felicidade;
   logic [7:0] sono;
   logic       morreu;
   logic [6:0] seg;
   logic [3:0] an;
   logic [1:0] pagina;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   mostrador_atributos #(.SCAN_DIV(4), .PAGE_DIV(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .estado     (estado),
      .fome       (fome),
      .felicidade (felicidade),
      .sono       (sono),
      .morreu     (morreu),
      .seg        (seg),
      .an         (an),
      .pagina     (pagina)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] pat(input int d);
      logic [6:0] s;
      case (d)
         0: s = 7'b1000000;
         1: s = 7'b1111001;
         2: s = 7'b0100100;
         3: s = 7'b0110000;
         4: s = 7'b0011001;
         5: s = 7'b0010010;
         6: s = 7'b0000010;
         7: s = 7'b1111000;
         8: s = 7'b0000000;
         9: s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Expected {digit2, digit1, digit0} patterns for a hundreds/tens/units triple.
   function automatic logic [20:0] num3(input int h, input int t, input int u);
      logic [6:0] d2, d1;
`ifdef MOSTRADOR_SUPRESSAO_ZEROS_EN
      d2 = (h == 0) ? BL : pat(h);
      d1 = (h == 0 && t == 0) ? BL : pat(t);
`else
      d2 = pat(h);
      d1 = pat(t);
`endif
      return {d2, d1, pat(u)};
   endfunction

   function automatic logic [6:0] exp_seg(input logic [3:0] a, input logic [6:0] d3,
                                          input logic [20:0] n);
      logic [6:0] s;
      case (a)
         4'b0111: s = d3;
         4'b1011: s = n[20:14];
         4'b1101: s = n[13:7];
         4'b1110: s = n[6:0];
         default: s = BL;
      endcase
      return s;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   // One clock edge, sampled 1 time unit later; one enable low at all times.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      check("an_onehot", 8'($countones(~an)), 8'd1);
   endtask

   task automatic go_to(input int n);
      while (cyc < n) tick();
   endtask

   // Watch a full scan round and compare every digit with the expectation.
   task automatic check_page(input string tag, input logic [6:0] d3, input logic [20:0] n);
      logic [6:0] c3, c2, c1, c0;
      c3 = 7'bx; c2 = 7'bx; c1 = 7'bx; c0 = 7'bx;
      for (int i = 0; i < 16; i++) begin
         tick();
         case (an)
            4'b0111: c3 = seg;
            4'b1011: c2 = seg;
            4'b1101: c1 = seg;
            4'b1110: c0 = seg;
            default: c3 = 7'bz;
         endcase
      end
      check({tag, "_d3"}, {1'b0, c3}, {1'b0, d3});
      check({tag, "_d2"}, {1'b0, c2}, {1'b0, n[20:14]});
      check({tag, "_d1"}, {1'b0, c1}, {1'b0, n[13:7]});
      check({tag, "_d0"}, {1'b0, c0}, {1'b0, n[6:0]});
   endtask

   initial begin
      rst        = 1'b1;
      estado     = 3'd5;
      fome       = 8'd255;
      felicidade = 8'd7;
      sono       = 8'd100;
      morreu     = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_pagina", {6'd0, pagina}, 8'd0);
      check("rst_an", {4'd0, an}, 8'b0111);
      check("rst_seg", {1'b0, seg}, {1'b0, BL});

      // Release; the first edge is the FOME entry
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      cyc = 0;

      go_to(8);
      check("pre_conv", {1'b0, seg}, {1'b0, exp_seg(an, LF, num3(0, 0, 0))});
      go_to(9);
      check("conv_latency", {1'b0, seg}, {1'b0, exp_seg(an, LF, num3(2, 5, 5))});
      check_page("fome255", LF, num3(2, 5, 5));
      check("pagina0", {6'd0, pagina}, 8'd0);

      // Page 1 entry exactly 64 cycles later; old digits stay for 9 cycles
      go_to(63);
      check("pagina0_end", {6'd0, pagina}, 8'd0);
      go_to(64);
      check("pagina1", {6'd0, pagina}, 8'd1);
      check("hold_prev", {1'b0, seg}, {1'b0, exp_seg(an, LF, num3(2, 5, 5))});
      go_to(73);
      check("felic_latency", {1'b0, seg}, {1'b0, exp_seg(an, LC, num3(0, 0, 7))});
      check_page("felic7", LC, num3(0, 0, 7));
      felicidade = 8'd200;
      check_page("felic_frozen", LC, num3(0, 0, 7));

      // Page 2: sono changes mid-page and must not show until next entry
      go_to(128);
      check("pagina2", {6'd0, pagina}, 8'd2);
      go_to(137);
      check_page("sono100", LS, num3(1, 0, 0));
      sono = 8'd42;
      check_page("sono_frozen", LS, num3(1, 0, 0));

      // Page 3: estado zero-extended
      go_to(192);
      check("pagina3", {6'd0, pagina}, 8'd3);
      go_to(201);
      check_page("estado5", LE, num3(0, 0, 5));

      // Back to page 0, then dead overlay
      go_to(256);
      check("pagina_wrap", {6'd0, pagina}, 8'd0);
      go_to(276);
      morreu = 1'b1;
      tick();
      check("dead_first", {1'b0, seg},
            {1'b0, exp_seg(an, LDD, {LE, LA, LDD})});
      check_page("dead", LDD, {LE, LA, LDD});
      morreu = 1'b0;
      #1;
      check("dead_release", {1'b0, seg}, {1'b0, exp_seg(an, LF, num3(2, 5, 5))});

      // Page 1 shows the updated felicidade, page 2 the updated sono
      go_to(329);
      check_page("felic200", LC, num3(2, 0, 0));
      go_to(384);
      check("pagina2_again", {6'd0, pagina}, 8'd2);
      go_to(393);
      check_page("sono42", LS, num3(0, 4, 2));

      // Reset 3 cycles after the page-3 entry
      go_to(451);
      rst  = 1'b1;
      fome = 8'd18;
      #1;
      check("midrst_seg", {1'b0, seg}, {1'b0, BL});
      check("midrst_an", {4'd0, an}, 8'b0111);
      check("midrst_pagina", {6'd0, pagina}, 8'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      cyc = 0;
      check("rerun_pagina", {6'd0, pagina}, 8'd0);
      go_to(9);
      check("rerun_latency", {1'b0, seg}, {1'b0, exp_seg(an, LF, num3(0, 1, 8))});
      check_page("fome18", LF, num3(0, 1, 8));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mostrador_atributos.md
MOSTRADOR_ATRIBUTOS -- requirements
Module: mostrador_atributos

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit-scan step, minimum 2.
REQ-002 SHALL have parameter PAGE_DIV, default 100000000: clk cycles per displayed page, minimum 16.
REQ-003 SHALL use one clock; reset is asynchronous and active-high. The clock port is clk and the reset port is rst.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous reset, active-high.
REQ-006 estado  input  3  pet state code from the state controller.
REQ-007 fome, felicidade, sono  input  8 each  attribute values from the attribute controller, unsigned 0-255.
REQ-008 morreu  input  1  pet-dead flag.
REQ-009 seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-010 an  output  4  digit enables, active-low, an[3] is the leftmost digit.
REQ-011 pagina  output  2  current page: 0=fome, 1=felicidade, 2=sono, 3=estado.

Function
REQ-012 Page FSM SHALL cycle FOME->FELICIDADE->SONO->ESTADO->FOME, advancing after exactly PAGE_DIV cycles per page.
REQ-013 On page entry, the FSM SHALL snapshot the page's value into an 8-bit register; the ESTADO page is zero-extended.
REQ-014 On the cycle after the snapshot, the FSM SHALL start a sequential double-dabble binary-to-BCD conversion, one shift per clk, 8 shifts total.
REQ-015 Decoded digits SHALL update 9 cycles after page entry; until then the previous page's digits stay displayed, and pagina changes immediately.
REQ-016 Input changes within a page SHALL NOT affect the displayed value until the next page entry.
REQ-017 The scan counter SHALL advance the active digit every SCAN_DIV cycles in the order 3,2,1,0,3; exactly one an bit is low at any time.
REQ-018 Digit 3 SHALL show the page letter: F=0001110 (fome), C=1000110 (felicidade), S=0010010 (sono), E=0000110 (estado).
REQ-019 Digits 2,1,0 SHALL show hundreds, tens and units using standard 0-9 active-low patterns (0=1000000, 5=0010010, 9=0010000).
REQ-020 While morreu=1, digits 3..0 SHALL show "dEAd": 0100001, 0000110, 0001000, 0100001. The page FSM keeps running and its value is ignored.
REQ-021 When morreu falls, normal digits SHALL resume on the same cycle, showing the latest converted value.
REQ-022 Both counters SHALL wrap to 0 without glitching an; there is no idle state.

Reset
REQ-023 While rst=1, outputs SHALL be: pagina=0, an=4'b0111, seg=7'b1111111 (blank), all BCD digits 0, both counters 0.
REQ-024 On rst release, the FSM SHALL enter FOME and snapshot fome on the first clk edge; a rst asserted mid-conversion aborts it with no partial digits retained.

Configuration
REQ-025 With macro MOSTRADOR_SUPRESSAO_ZEROS_EN defined, leading zero digits 2 and 1 SHALL be blanked (1111111), and digit 0 is always shown.
REQ-026 Without MOSTRADOR_SUPRESSAO_ZEROS_EN, all three numeric digits SHALL always be shown, including leading zeros.

Verification
REQ-027 SCAN_DIV=4, PAGE_DIV=64, fome=8'd255, morreu=0, release rst -> after 9 cycles the scan shows F,2,5,5; pagina=0.
REQ-028 felicidade=8'd7 at page 1 entry, macro undefined -> C,0,0,7; macro defined -> C,blank,blank,7.
REQ-029 Change sono from 100 to 42 mid-page 2 -> display stays S,1,0,0 until the next page-2 entry, which shows S,0,4,2.
REQ-030 Assert morreu mid-page -> dEAd on the next scan step; deassert -> the current page digits return on the same cycle.
REQ-031 Assert rst 3 cycles after page entry -> seg=1111111, an=0111, pagina=0 immediately; after release, FOME is re-converted cleanly.
REQ-032 Run 4*PAGE_DIV cycles -> pagina sequence 0,1,2,3,0, and exactly one an bit is low every cycle.
